// File: rtl/cla_sub16_pipe_pkg.sv
// Shared types and helpers for the pipelined CLA subtractor.
// The result bundle keeps the difference and its flags together so they move as one register.
package cla_sub16_pipe_pkg;

    localparam int DW = 16;

    // Packed layout, LSB first: zero at bit 0, ovf at bit 1, borrow at bit 2, difference above.
    localparam int FLAG_ZERO   = 0;
    localparam int FLAG_OVF    = 1;
    localparam int FLAG_BORROW = 2;

    typedef struct packed {
        logic [DW-1:0] out;
        logic          borrow;
        logic          ovf;
        logic          zero;
    } sub_result_t;

    // Build the result bundle from the adder output; a is the minuend, b the raw subtrahend.
    function automatic sub_result_t make_result(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic [DW-1:0] d,
        input logic          cout
    );
        sub_result_t r;
        logic [2:0]  flags;
        flags              = '0;
        flags[FLAG_BORROW] = ~cout;
        flags[FLAG_OVF]    = (a[DW-1] != b[DW-1]) && (d[DW-1] != a[DW-1]);
        flags[FLAG_ZERO]   = (d == '0);
        r.out    = d;
        r.borrow = flags[FLAG_BORROW];
        r.ovf    = flags[FLAG_OVF];
        r.zero   = flags[FLAG_ZERO];
        return r;
    endfunction

endpackage

// File: rtl/cla_sub16_pipe_cla.sv
// Two-level carry-lookahead adder: 4-bit groups with internal lookahead,
// group generate/propagate combined across groups for the group carries.
module CLA_16bit_LookAheadUnit #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gc;

    assign g = in1 & in2;
    assign p = in1 ^ in2;

    for (genvar i = 0; i < NG; i++) begin : g_group
        localparam int B = 4 * i;

        assign gp[i] = p[B+3] & p[B+2] & p[B+1] & p[B];
        assign gg[i] = g[B+3]
                     | (p[B+3] & g[B+2])
                     | (p[B+3] & p[B+2] & g[B+1])
                     | (p[B+3] & p[B+2] & p[B+1] & g[B]);

        // Bit carries inside the group depend only on the group's incoming carry.
        assign c[B]   = gc[i];
        assign c[B+1] = g[B] | (p[B] & gc[i]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[i]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & gc[i]);
    end

    always_comb begin
        gc[0] = cin;
        for (int i = 0; i < NG; i++) begin
            gc[i+1] = gg[i] | (gp[i] & gc[i]);
        end
    end

    assign sum  = p ^ c;
    assign cout = gc[NG];

endmodule

// File: rtl/cla_sub16_pipe.sv
// Two-stage pipelined subtractor (out = in1 - in2) on the lookahead adder, with
// valid/ready on both ends and registered borrow / signed-overflow / zero flags.
module cla_sub16_pipe
    import cla_sub16_pipe_pkg::*;
#(
    parameter int WIDTH = DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    logic             s1_valid;
    logic             s2_valid;
    logic [WIDTH-1:0] in1_reg;
    logic [WIDTH-1:0] in2_reg;
    logic [WIDTH-1:0] diff;
    logic             cout;
    logic             adv1;
    logic             adv2;
    sub_result_t      s2_res;
    sub_result_t      s2_next;

    // A stage may load when it is empty or its contents leave downstream this cycle.
    assign adv2     = !s2_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    CLA_16bit_LookAheadUnit #(
        .WIDTH (WIDTH)
    ) u_cla (
        .in1  (in1_reg),
        .in2  (~in2_reg),
        .cin  (1'b1),
        .sum  (diff),
        .cout (cout)
    );

    always_comb begin
        s2_next = make_result(in1_reg, in2_reg, diff, cout);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            in1_reg  <= '0;
            in2_reg  <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                in1_reg <= in1;
                in2_reg <= in2;
            end
        end
    end

    // Data only moves on a real S1 entry, so a stalled result stays put while out_valid is low too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res <= s2_next;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out       = s2_res.out;
    assign borrow    = s2_res.borrow;
    assign ovf       = s2_res.ovf;
    assign zero      = s2_res.zero;

endmodule

// File: tb/tb_cla_sub16_pipe.sv
// Scoreboard bench for cla_sub16_pipe: the driver pushes model results on each accepted
// pair, a negedge monitor pops and compares whenever a result is handed off.
module tb_cla_sub16_pipe;

    typedef struct packed {
        logic [15:0] out;
        logic        borrow;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out;
    logic        borrow;
    logic        ovf;
    logic        zero;

    int   vectors = 0;
    int   miscompares = 0;
    int   or_mode = 0;
    exp_t exp_q[$];
    bit   stalled_prev = 1'b0;

    cla_sub16_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .borrow    (borrow),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the unsigned and signed readings of the operands.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   ua, ub, sa, sb, sd;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        sd = sa - sb;
        e.out    = 16'((ua - ub + 65536) % 65536);
        e.borrow = (ua < ub);
        e.ovf    = (sd > 32767) || (sd < -32768);
        e.zero   = (ua == ub);
        return e;
    endfunction

    function automatic exp_t mk(input logic [15:0] o, input logic b, input logic v, input logic z);
        exp_t e;
        e.out = o; e.borrow = b; e.ovf = v; e.zero = z;
        return e;
    endfunction

    task automatic checkOutput(input string name, input exp_t e);
        vectors++;
        if ({out, borrow, ovf, zero} !== e) begin
            miscompares++;
            $display("[TB] FAIL %s: got out=%h borrow=%b ovf=%b zero=%b, expected out=%h borrow=%b ovf=%b zero=%b",
                     name, out, borrow, ovf, zero, e.out, e.borrow, e.ovf, e.zero);
        end
    endtask

    task automatic check_int(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Present one pair from posedge+1 until the negedge that sees in_ready, then hand back at posedge+1.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input bit use_exp, input exp_t e_in);
        exp_t e;
        int   waited;
        bit   done;
        e      = use_exp ? e_in : model(a, b);
        in_valid = 1'b1;
        in1    = a;
        in2    = b;
        waited = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end else if (waited >= 200) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
                done = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in1 = 16'($urandom);
        in2 = 16'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_int("drain_pending", exp_q.size(), 0);
    endtask

    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Every presented result must match the queue head; stalled ones are re-checked each cycle.
    always @(negedge clk) begin
        if (!rst) begin
            stalled_prev = 1'b0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_result: got out=%h with out_valid=1, expected no result", out);
            end else begin
                checkOutput(out_ready ? "result" : "stalled_result", exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
            stalled_prev = !out_ready;
        end else begin
            if (stalled_prev) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL valid_dropped: got out_valid=0, expected 1 until handshake");
            end
            stalled_prev = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        time t0;
        int  pick;
        logic [15:0] corners [6];
        logic [15:0] a, b;
        corners = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h5A5A};

        idle(3);
        checkOutput("reset_outputs", mk(16'h0000, 1'b0, 1'b0, 1'b0));
        check_int("reset_out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        check_int("in_ready_after_reset", int'(in_ready), 1);

        or_mode = 0;
        out_ready = 1'b1;
        applyStimulus(16'h1234, 16'h0234, 1'b1, mk(16'h1000, 1'b0, 1'b0, 1'b0));
        applyStimulus(16'h0000, 16'h0001, 1'b1, mk(16'hFFFF, 1'b1, 1'b0, 1'b0));
        applyStimulus(16'h5A5A, 16'h5A5A, 1'b1, mk(16'h0000, 1'b0, 1'b0, 1'b1));
        applyStimulus(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b0, 1'b1, 1'b0));
        applyStimulus(16'h7FFF, 16'hFFFF, 1'b1, mk(16'h8000, 1'b1, 1'b1, 1'b0));
        drain();

        t0 = $time;
        for (int i = 0; i < 6; i++) applyStimulus(16'($urandom), 16'($urandom), 1'b0, mk(0, 0, 0, 0));
        check_int("throughput_cycles", int'(($time - t0) / 10), 6);
        drain();

        or_mode = 2;
        out_ready = 1'b0;
        idle(1);
        fork
            for (int i = 0; i < 4; i++) applyStimulus(16'($urandom), 16'($urandom), 1'b0, mk(0, 0, 0, 0));
        join_none
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_int("bp_in_ready", int'(in_ready), 0);
        check_int("bp_accepted", exp_q.size(), 2);
        or_mode = 1;
        wait fork;
        or_mode = 0;
        drain();

        or_mode = 2;
        out_ready = 1'b0;
        idle(1);
        applyStimulus(16'h4321, 16'h1111, 1'b0, mk(0, 0, 0, 0));
        applyStimulus(16'h9999, 16'h0F0F, 1'b0, mk(0, 0, 0, 0));
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midreset_outputs", mk(16'h0000, 1'b0, 1'b0, 1'b0));
        check_int("midreset_out_valid", int'(out_valid), 0);
        exp_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b1;
        or_mode = 0;
        #1;
        check_int("midreset_in_ready", int'(in_ready), 1);
        idle(6);
        check_int("midreset_no_stale", int'(out_valid), 0);

        or_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                pick = int'($urandom_range(0, 9));
                a = (pick == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
                b = (pick == 1) ? corners[$urandom_range(0, 5)] : 16'($urandom);
                if (pick == 2) b = a;
                applyStimulus(a, b, 1'b0, mk(0, 0, 0, 0));
            end
        end
        or_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
